// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite loader: default sprite geometry, byte type
// and the loader state encoding.
package sprite_pkg;
    localparam int DEF_WIDTH  = 12;
    localparam int DEF_HEIGHT = 12;
    localparam int DEF_N      = DEF_WIDTH * DEF_HEIGHT;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        PAUSE
    } state_t;
endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with wrap-bit pointers; DEPTH must be a power of two.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module byte_fifo
    import sprite_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  logic  pop_i,
    input  byte_t data_i,
    output byte_t data_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int AW = $clog2(DEPTH);

    byte_t       r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign data_o    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/sprite_loader.sv
// Sprite loader: receives a sprite bitmap over SPI and inserts it bit-serially into
// the sprite shift-register store during vblank; otherwise forwards renderer shifts.
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic spi_sclk_i,
    input  logic spi_mosi_i,
    input  logic spi_cs_ni,
    input  logic vblank_i,
    input  logic render_shift_i,
    output logic shift_o,
    output logic load_o,
    output logic data_o,
    output logic busy_o,
    output logic done_o,
    output logic overflow_o,
    output logic frame_err_o
);
    localparam int NBITS = WIDTH * HEIGHT;
    localparam int INS_W = $clog2(NBITS);
    localparam int TXN_W = $clog2(NBITS + 1) + 1;
    localparam logic [TXN_W-1:0] TXN_MAX   = '1;
    localparam logic [TXN_W-1:0] TXN_FRAME = TXN_W'(NBITS);
    localparam logic [INS_W-1:0] INS_LAST  = INS_W'(NBITS - 1);

    logic [1:0]       r_sclk_sync;
    logic [1:0]       r_mosi_sync;
    logic [1:0]       r_cs_sync;
    logic             r_sclk_d;
    logic             r_cs_d;
    logic             r_in_txn;
    logic [2:0]       r_rx_bits;
    logic [6:0]       r_rx_shift;
    logic [TXN_W-1:0] r_txn_cnt;
    logic             r_overflow;
    logic             r_frame_err;

    logic [2:0]       r_drain_bit;
    logic [INS_W-1:0] r_ins_cnt;
    state_t           r_state;

    logic  w_sclk_rise;
    logic  w_cs_fall;
    logic  w_cs_rise;
    logic  w_bit_take;
    logic  w_byte_done;
    byte_t w_rx_byte;
    byte_t w_head;
    logic  w_full;
    logic  w_empty;
    logic  w_drain;
    logic  w_pop;
    logic  w_ins_wrap;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_cs_fall   = r_cs_d & ~r_cs_sync[1];
    assign w_cs_rise   = ~r_cs_d & r_cs_sync[1];
    // Only count bits inside a transaction whose falling CS edge was seen, so that
    // synchronizers settling after reset cannot fake a bit or a frame error.
    assign w_bit_take  = w_sclk_rise & ~r_cs_sync[1] & r_in_txn;
    assign w_byte_done = w_bit_take & (r_rx_bits == 3'd7);
    assign w_rx_byte   = {r_rx_shift, r_mosi_sync[1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
            r_in_txn    <= 1'b0;
            r_rx_bits   <= '0;
            r_rx_shift  <= '0;
            r_txn_cnt   <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_sclk_i};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi_i};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_ni};
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_d      <= r_cs_sync[1];
            if (w_cs_fall) begin
                r_in_txn  <= 1'b1;
                r_txn_cnt <= '0;
                r_rx_bits <= '0;
            end else if (w_cs_rise) begin
                if (r_in_txn && (r_txn_cnt != TXN_FRAME || r_rx_bits != 3'd0)) begin
                    r_frame_err <= 1'b1;
                end
                r_in_txn  <= 1'b0;
                r_rx_bits <= '0;
            end else if (w_bit_take) begin
                r_rx_shift <= w_rx_byte[6:0];
                r_rx_bits  <= r_rx_bits + 3'd1;
                if (r_txn_cnt != TXN_MAX) r_txn_cnt <= r_txn_cnt + 1'b1;
                if (w_byte_done && w_full && !w_pop) r_overflow <= 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_byte_done),
        .pop_i   (w_pop),
        .data_i  (w_rx_byte),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_drain    = vblank_i & ~w_empty;
    assign w_pop      = w_drain & (r_drain_bit == 3'd7);
    assign w_ins_wrap = w_drain & (r_ins_cnt == INS_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drain_bit <= '0;
            r_ins_cnt   <= '0;
            r_state     <= IDLE;
        end else begin
            if (w_drain) begin
                r_drain_bit <= r_drain_bit + 3'd1;
                r_ins_cnt   <= w_ins_wrap ? '0 : r_ins_cnt + 1'b1;
            end
            unique case (r_state)
                IDLE, PAUSE: if (w_drain) r_state <= w_ins_wrap ? IDLE : DRAIN;
                DRAIN: begin
                    if (w_ins_wrap)    r_state <= IDLE;
                    else if (!w_drain) r_state <= PAUSE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gating the pass-through with reset keeps every output low during reset.
    assign shift_o     = w_drain | (render_shift_i & rst_ni);
    assign load_o      = w_drain;
    assign data_o      = w_drain & w_head[3'd7 - r_drain_bit];
    assign done_o      = w_ins_wrap;
    assign busy_o      = (r_state != IDLE) | ~w_empty;
    assign overflow_o  = r_overflow;
    assign frame_err_o = r_frame_err;
endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: stimulus queues the expected insert stream,
// a monitor checks inserts and pass-through against it and models the external store.
module tb_sprite_loader;
    import sprite_pkg::*;

    localparam int NB     = DEF_N;
    localparam int NBYTES = NB / 8;
    localparam int DEPTH  = 4;

    logic clk_i          = 1'b0;
    logic rst_ni         = 1'b0;
    logic spi_sclk_i     = 1'b0;
    logic spi_mosi_i     = 1'b0;
    logic spi_cs_ni      = 1'b1;
    logic vblank_i       = 1'b0;
    logic render_shift_i = 1'b0;
    logic shift_o, load_o, data_o, busy_o, done_o, overflow_o, frame_err_o;

    sprite_loader #(
        .WIDTH      (DEF_WIDTH),
        .HEIGHT     (DEF_HEIGHT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .spi_sclk_i     (spi_sclk_i),
        .spi_mosi_i     (spi_mosi_i),
        .spi_cs_ni      (spi_cs_ni),
        .vblank_i       (vblank_i),
        .render_shift_i (render_shift_i),
        .shift_o        (shift_o),
        .load_o         (load_o),
        .data_o         (data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o),
        .frame_err_o    (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int    errors = 0;
    int    checks = 0;
    bit    exp_q[$];
    int    ins_seen  = 0;
    int    done_seen = 0;
    int    img_pos   = 0;
    int    half      = 2;
    bit    store[NB];
    bit    image[NB];
    byte_t bytes[NBYTES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s", name, what);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Bytes the bench knows will be accepted are appended to the expected stream.
    task automatic queue_byte(input byte_t b);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(b[i]);
            image[img_pos] = b[i];
            img_pos = (img_pos + 1) % NB;
        end
    endtask

    task automatic spi_bit(input bit b);
        spi_mosi_i = b;
        tick(half);
        spi_sclk_i = 1'b1;
        tick(half);
        spi_sclk_i = 1'b0;
    endtask

    task automatic spi_byte(input byte_t b, input bit accepted);
        if (accepted) queue_byte(b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_start();
        spi_cs_ni = 1'b0;
        tick(3);
    endtask

    task automatic cs_end();
        tick(3);
        spi_cs_ni = 1'b1;
        tick(5);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        ins_seen  = 0;
        done_seen = 0;
        img_pos   = 0;
        for (int k = 0; k < NB; k++) store[k] = 1'b0;
        tick(3);
        rst_ni = 1'b1;
        tick(5);
    endtask

    task automatic wait_drained(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 600) begin
            tick(1);
            t++;
        end
        if (exp_q.size() != 0) fail(name, "drain timeout, required empty scoreboard");
        tick(4);
    endtask

    task automatic wait_inserts(input int n);
        int t = 0;
        while (ins_seen < n && t < 3000) begin
            tick(1);
            t++;
        end
        if (ins_seen < n) fail("wait_inserts", "insert count timeout, required target reached");
    endtask

    task automatic render_frame();
        render_shift_i = 1'b1;
        tick(NB);
        render_shift_i = 1'b0;
        tick(2);
    endtask

    function automatic int image_mismatches();
        int n = 0;
        for (int k = 0; k < NB; k++) if (store[k] !== image[k]) n++;
        return n;
    endfunction

    // Monitor: inserts pop the scoreboard, other cycles must be pure pass-through.
    initial begin
        bit e;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (load_o) begin
                    check("load_in_vblank", vblank_i, 1'b1);
                    check("shift_on_load", shift_o, 1'b1);
                    if (exp_q.size() == 0) begin
                        fail("unexpected_insert", "insert with empty scoreboard, required none");
                    end else begin
                        e = exp_q.pop_front();
                        check("insert_bit", data_o, e);
                    end
                    check("done_on_insert", done_o, (ins_seen == NB - 1));
                    if (done_o) done_seen++;
                    ins_seen = (ins_seen + 1) % NB;
                    for (int k = 0; k < NB - 1; k++) store[k] = store[k + 1];
                    store[NB - 1] = data_o;
                end else begin
                    check("pass_shift", shift_o, render_shift_i);
                    check("pass_data", data_o, 1'b0);
                    check("idle_done", done_o, 1'b0);
                    if (shift_o) begin
                        e = store[0];
                        for (int k = 0; k < NB - 1; k++) store[k] = store[k + 1];
                        store[NB - 1] = e;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, checked while held and after release.
        tick(2);
        check("rst_shift", shift_o, 1'b0);
        check("rst_load", load_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        do_reset();
        check("idle_busy", busy_o, 1'b0);
        check("idle_overflow", overflow_o, 1'b0);
        check("idle_frame_err", frame_err_o, 1'b0);
        check("idle_data", data_o, 1'b0);

        // Full sprite with vblank high, then a renderer readback frame.
        half = int'($urandom_range(2, 3));
        for (int i = 0; i < NBYTES; i++) bytes[i] = byte_t'($urandom);
        vblank_i = 1'b1;
        cs_start();
        for (int i = 0; i < NBYTES; i++) spi_byte(bytes[i], 1'b1);
        cs_end();
        wait_drained("full_load");
        check("full_done_count", done_seen, 1);
        check("full_frame_err", frame_err_o, 1'b0);
        check("full_overflow", overflow_o, 1'b0);
        check("full_busy", busy_o, (ins_seen != 0) || (exp_q.size() != 0));
        check("full_lsb", store[0], bytes[0][7]);
        check("full_image", image_mismatches(), 0);
        vblank_i = 1'b0;
        render_frame();
        check("readback_image", image_mismatches(), 0);

        // vblank drops after 40 inserts; renderer rotates a full frame; load resumes.
        do_reset();
        half = int'($urandom_range(2, 3));
        for (int i = 0; i < NBYTES; i++) bytes[i] = byte_t'($urandom);
        vblank_i = 1'b1;
        cs_start();
        fork
            for (int i = 0; i < 6; i++) spi_byte(bytes[i], 1'b1);
            begin
                wait_inserts(40);
                vblank_i = 1'b0;
            end
        join
        check("pause_count", ins_seen, 40);
        check("pause_busy", busy_o, 1'b1);
        render_frame();
        check("pause_hold", ins_seen, 40);
        vblank_i = 1'b1;
        for (int i = 6; i < NBYTES; i++) spi_byte(bytes[i], 1'b1);
        cs_end();
        wait_drained("pause_load");
        check("pause_done_count", done_seen, 1);
        check("pause_frame_err", frame_err_o, 1'b0);
        check("pause_image", image_mismatches(), 0);

        // Six bytes at full SPI rate with vblank low: the fifth and sixth are dropped.
        do_reset();
        half = 2;
        vblank_i = 1'b0;
        cs_start();
        for (int i = 0; i < 6; i++) begin
            spi_byte(byte_t'($urandom), i < DEPTH);
            tick(5);
            if (i == DEPTH - 1) check("ovf_before", overflow_o, 1'b0);
            if (i == DEPTH)     check("ovf_after", overflow_o, 1'b1);
        end
        cs_end();
        check("ovf_busy", busy_o, 1'b1);
        vblank_i = 1'b1;
        wait_drained("ovf_drain");
        tick(20);
        check("ovf_inserts", ins_seen, 8 * DEPTH);
        check("ovf_busy_after", busy_o, (ins_seen != 0) || (exp_q.size() != 0));

        // CS released after 13 bits: one byte kept, the partial byte discarded.
        do_reset();
        half = int'($urandom_range(2, 3));
        vblank_i = 1'b0;
        cs_start();
        spi_byte(byte_t'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom));
        cs_end();
        check("ferr_set", frame_err_o, 1'b1);
        check("ferr_overflow", overflow_o, 1'b0);
        check("ferr_busy", busy_o, 1'b1);
        vblank_i = 1'b1;
        wait_drained("ferr_drain");
        check("ferr_inserts", ins_seen, 8);
        cs_start();
        spi_byte(byte_t'($urandom), 1'b1);
        cs_end();
        wait_drained("ferr_next");
        check("ferr_sticky", frame_err_o, 1'b1);
        check("ferr_next_inserts", ins_seen, 16);

        // Pass-through with the FIFO empty and vblank low.
        do_reset();
        vblank_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            render_shift_i = 1'($urandom);
            tick(1);
        end
        render_shift_i = 1'b1;
        #1;
        check("pt_shift_now", shift_o, 1'b1);
        check("pt_load_now", load_o, 1'b0);
        render_shift_i = 1'b0;
        #1;
        check("pt_shift_low", shift_o, 1'b0);
        tick(1);

        // Reset asserted mid-drain.
        vblank_i = 1'b0;
        cs_start();
        for (int i = 0; i < 3; i++) spi_byte(byte_t'($urandom), 1'b1);
        cs_end();
        vblank_i = 1'b1;
        wait_inserts(10);
        check("mid_load_active", load_o, 1'b1);
        rst_ni = 1'b0;
        exp_q.delete();
        ins_seen = 0;
        #1;
        check("mid_rst_shift", shift_o, 1'b0);
        check("mid_rst_load", load_o, 1'b0);
        check("mid_rst_data", data_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_frame_err", frame_err_o, 1'b0);
        tick(3);
        rst_ni = 1'b1;
        tick(8);
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_load", load_o, 1'b0);
        check("post_rst_overflow", overflow_o, 1'b0);
        check("post_rst_frame_err", frame_err_o, 1'b0);
        vblank_i = 1'b0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Write side of the sprite shift-register interface: receives a new sprite bitmap over an SPI-style serial port and inserts it into the sprite store.
- Drives the store's shift-enable, load-select and serial-data inputs.
- Between loads, passes the renderer's shift requests straight through to the store.
- Sits between the top-level SPI pins, the video timing generator (vblank) and the sprite store.

Parameters:
- WIDTH, 12, sprite width in pixels.
- HEIGHT, 12, sprite height in pixels.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous reset, active low.
- spi_sclk_i  input  1  serial clock; asynchronous; period at least 4 clk_i cycles.
- spi_mosi_i  input  1  serial data; asynchronous.
- spi_cs_ni  input  1  chip select, active low; asynchronous.
- vblank_i  input  1  high while no sprite pixels are fetched.
- render_shift_i  input  1  renderer's per-pixel shift request.
- shift_o  output  1  to the store's shift enable.
- load_o  output  1  to the store's load select.
- data_o  output  1  to the store's serial data input.
- busy_o  output  1  a load is in progress (bit count nonzero or FIFO not empty).
- done_o  output  1  one-cycle pulse when the last bit of a sprite is inserted.
- overflow_o  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err_o  output  1  sticky: a CS transaction ended with a bit count other than N or with a partial byte.

Behaviour:
- Define N = WIDTH*HEIGHT. N must be a multiple of 8; N/8 bytes form one sprite.
- Reset: all outputs 0; FIFO empty; all counters 0; synchronizers cleared.
- Synchronisers: two-flop synchronizers on sclk, mosi and cs_n.
  - A bit is sampled on the synchronized rising edge of sclk while cs_n is low.
  - Bytes are received MSB first.
  - Total latency from pin to FIFO is 3-4 clk_i cycles.
- Receive side:
  - After 8 bits, the byte is pushed into the FIFO.
  - If the FIFO is full, the byte is dropped and overflow_o is set.
  - The transaction bit counter clears on the cs_n falling edge.
  - On the cs_n rising edge, frame_err_o is set if the counter is not equal to N. A partial byte is discarded and also sets frame_err_o.
- Drain side (one bit per cycle):
  - Active only while vblank_i is high and the FIFO is not empty.
  - Each drain cycle: shift_o=1, load_o=1, data_o = next bit, MSB of the head byte first.
  - The FIFO pops after the 8th bit of the head byte.
  - The insert counter increments each drain cycle. On reaching N-1 it wraps to 0 and done_o pulses in that same cycle.
- Stream order equals pixel order: the first received bit becomes pixel 0.
- Pass-through:
  - When not draining, shift_o = render_shift_i combinationally, load_o=0, data_o=0.
  - While draining, render_shift_i is ignored. Contract: the renderer does not shift during vblank.
- vblank falls mid-load:
  - Draining pauses and the insert counter and head-byte bit index hold.
  - Contract: the renderer performs exactly N shifts per frame. N rotations is the identity, so insertion resumes correctly next vblank.
- Simultaneous push and pop in one cycle: both take effect, and the FIFO level is unchanged.
- A new cs_n transaction while a drain is in progress is legal; bytes queue behind the current ones.
- Sticky flags clear only on reset.
- Reset mid-load: the partial sprite is abandoned. The store reloads its own default image on the same reset.

Decomposition:
- Shared package sprite_pkg holds:
  - the WIDTH/HEIGHT defaults, and N derived from them;
  - a byte typedef;
  - the loader state enum {IDLE, DRAIN, PAUSE}.
- The FIFO is a sub-module named byte_fifo (parameter DEPTH; push/pop/full/empty). It is reusable elsewhere.
- The SPI synchronizer and edge detector stay inline.

Test Plan:
- Reset, then 18 bytes with vblank held high → the store receives 144 inserts with load_o=1. done_o pulses once on the 144th insert. The store's LSB then equals bit 7 of byte 0, and a full readback via the renderer matches the stream.
- Load started and vblank dropped after 40 inserts; renderer does 144 shifts; vblank raised again → draining resumes at insert 41, and the final image is correct.
- 6 bytes sent at maximum SPI rate with vblank low (FIFO_DEPTH=4) → overflow_o=1 after the 5th byte; 4 bytes remain in the FIFO.
- cs_n raised after 13 bits → frame_err_o=1; one byte is in the FIFO; the partial 5 bits are discarded.
- vblank low and render_shift_i toggled with the FIFO empty → shift_o tracks render_shift_i in the same cycle; load_o stays 0.
- rst_ni asserted mid-drain → all outputs 0 in the same cycle; busy_o=0 after release.
